// File: rtl/ufo_rx_packet_validator.sv
// Store-and-forward receive validator: buffers each packet, checks the leading
// big-endian length field against the received byte count, forwards good packets.
module ufo_rx_packet_validator #(
  parameter int UFO_DATA_WIDTH = 64,
  parameter int MAX_SESSIONS   = 512,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                            clk,
  input  logic                            areset_n,
  input  logic [UFO_DATA_WIDTH-1:0]       ufo_rx_data,
  input  logic                            ufo_rx_startofpacket,
  input  logic                            ufo_rx_endofpacket,
  input  logic [2:0]                      ufo_rx_empty,
  input  logic                            ufo_rx_valid,
  input  logic [$clog2(MAX_SESSIONS)-1:0] ufo_rx_channel,
  output logic                            ufo_rx_ready,
  output logic [UFO_DATA_WIDTH-1:0]       ufo_out_data,
  output logic                            ufo_out_startofpacket,
  output logic                            ufo_out_endofpacket,
  output logic [2:0]                      ufo_out_empty,
  output logic                            ufo_out_valid,
  output logic [$clog2(MAX_SESSIONS)-1:0] ufo_out_channel,
  input  logic                            ufo_out_ready,
  output logic                            ufo_drop_pulse,
  output logic [15:0]                     ufo_drop_count
);

  localparam int CW = $clog2(MAX_SESSIONS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [19:0] BYTES    = 20'(UFO_DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE = 2'd0, RECEIVE = 2'd1, DISCARD = 2'd2} state_t;

  state_t            state_r, state_nxt_s;
  logic [AW:0]       wr_r, cm_r, rd_r, wr_nxt_s, cm_nxt_s;
  logic [AW:0]       beats_r, beats_nxt_s, beats_cur_s;
  logic [15:0]       len_r, len_nxt_s, len_cur_s;
  logic [CW-1:0]     chan_r, chan_nxt_s, chan_cur_s;
  logic              run_r;
  logic              acc_s, full_s, overflow_s, good_s, start_s, we_s, load_s;
  logic [AW-1:0]     waddr_s;
  logic [1:0]        drop_n_s;
  logic [19:0]       bytes_s;
  logic [16:0]       cnt_sum_s;

  logic [UFO_DATA_WIDTH-1:0] mem_data  [FIFO_DEPTH];
  logic                      mem_sop   [FIFO_DEPTH];
  logic                      mem_eop   [FIFO_DEPTH];
  logic [2:0]                mem_empty [FIFO_DEPTH];
  logic [CW-1:0]             mem_chan  [FIFO_DEPTH];

  // Only a buffer full of already-committed data may back-pressure; a full buffer
  // holding nothing but the open packet is resolved by discarding that packet.
  assign full_s       = ((wr_r - rd_r) == PTR_FULL);
  assign overflow_s   = (state_r == RECEIVE) && full_s && (cm_r == rd_r);
  assign ufo_rx_ready = run_r && !(full_s && (cm_r != rd_r));
  assign acc_s        = ufo_rx_valid && ufo_rx_ready;
  assign load_s       = (rd_r != cm_r) && (!ufo_out_valid || ufo_out_ready);

  assign beats_cur_s = ufo_rx_startofpacket ? PTR_ONE : (beats_r + PTR_ONE);
  assign len_cur_s   = ufo_rx_startofpacket ? ufo_rx_data[UFO_DATA_WIDTH-1 -: 16] : len_r;
  assign chan_cur_s  = ufo_rx_startofpacket ? ufo_rx_channel : chan_r;
  assign bytes_s     = (20'(beats_cur_s) * BYTES) - 20'(ufo_rx_empty);
  assign good_s      = (bytes_s == (20'(len_cur_s) + 20'd2)) && (len_cur_s != 16'd0);
  assign cnt_sum_s   = {1'b0, ufo_drop_count} + {15'd0, drop_n_s};

  // Receive FSM next state, buffer write and pointer updates.
  always_comb begin
    state_nxt_s = state_r;
    wr_nxt_s    = wr_r;
    cm_nxt_s    = cm_r;
    we_s        = 1'b0;
    waddr_s     = wr_r[AW-1:0];
    beats_nxt_s = beats_r;
    len_nxt_s   = len_r;
    chan_nxt_s  = chan_r;
    drop_n_s    = 2'd0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s && ufo_rx_startofpacket) start_s = 1'b1;
        else                               start_s = 1'b0;
      end
      RECEIVE: begin
        if (overflow_s) begin
          wr_nxt_s = cm_r;
          drop_n_s = 2'd1;
          if (acc_s && ufo_rx_startofpacket)    start_s     = 1'b1;
          else if (acc_s && ufo_rx_endofpacket) state_nxt_s = IDLE;
          else                                  state_nxt_s = DISCARD;
        end else if (acc_s && ufo_rx_startofpacket) begin
          drop_n_s = 2'd1;
          start_s  = 1'b1;
        end else if (acc_s) begin
          we_s        = 1'b1;
          beats_nxt_s = beats_cur_s;
          if (ufo_rx_endofpacket) begin
            state_nxt_s = IDLE;
            if (good_s) begin
              wr_nxt_s = wr_r + PTR_ONE;
              cm_nxt_s = wr_r + PTR_ONE;
            end else begin
              wr_nxt_s = cm_r;
              drop_n_s = 2'd1;
            end
          end else begin
            wr_nxt_s = wr_r + PTR_ONE;
          end
        end else begin
          state_nxt_s = RECEIVE;
        end
      end
      DISCARD: begin
        if (acc_s && ufo_rx_startofpacket)    start_s     = 1'b1;
        else if (acc_s && ufo_rx_endofpacket) state_nxt_s = IDLE;
        else                                  state_nxt_s = DISCARD;
      end
      default: state_nxt_s = IDLE;
    endcase
    // In IDLE and DISCARD wr equals cm, so every new packet starts at cm.
    if (start_s) begin
      we_s        = 1'b1;
      waddr_s     = cm_r[AW-1:0];
      beats_nxt_s = PTR_ONE;
      len_nxt_s   = len_cur_s;
      chan_nxt_s  = ufo_rx_channel;
      if (ufo_rx_endofpacket) begin
        state_nxt_s = IDLE;
        if (good_s) begin
          wr_nxt_s = cm_r + PTR_ONE;
          cm_nxt_s = cm_r + PTR_ONE;
        end else begin
          wr_nxt_s = cm_r;
          drop_n_s = drop_n_s + 2'd1;
        end
      end else begin
        state_nxt_s = RECEIVE;
        wr_nxt_s    = cm_r + PTR_ONE;
      end
    end else begin
      len_nxt_s = len_nxt_s;
    end
  end

  // Receive-side state, pointers, per-packet context and drop statistics.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_r        <= IDLE;
      wr_r           <= PTR_ZERO;
      cm_r           <= PTR_ZERO;
      beats_r        <= PTR_ZERO;
      len_r          <= 16'd0;
      chan_r         <= {CW{1'b0}};
      run_r          <= 1'b0;
      ufo_drop_pulse <= 1'b0;
      ufo_drop_count <= 16'd0;
    end else begin
      state_r        <= state_nxt_s;
      wr_r           <= wr_nxt_s;
      cm_r           <= cm_nxt_s;
      beats_r        <= beats_nxt_s;
      len_r          <= len_nxt_s;
      chan_r         <= chan_nxt_s;
      run_r          <= 1'b1;
      ufo_drop_pulse <= (drop_n_s != 2'd0);
      ufo_drop_count <= cnt_sum_s[16] ? 16'hFFFF : cnt_sum_s[15:0];
    end
  end

  // Packet buffer storage; visibility is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_data[waddr_s]  <= ufo_rx_data;
      mem_sop[waddr_s]   <= ufo_rx_startofpacket;
      mem_eop[waddr_s]   <= ufo_rx_endofpacket;
      mem_empty[waddr_s] <= ufo_rx_endofpacket ? ufo_rx_empty : 3'd0;
      mem_chan[waddr_s]  <= chan_cur_s;
    end
  end

  // Registered output stage draining committed entries between rd and cm.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rd_r                  <= PTR_ZERO;
      ufo_out_valid         <= 1'b0;
      ufo_out_data          <= {UFO_DATA_WIDTH{1'b0}};
      ufo_out_startofpacket <= 1'b0;
      ufo_out_endofpacket   <= 1'b0;
      ufo_out_empty         <= 3'd0;
      ufo_out_channel       <= {CW{1'b0}};
    end else if (load_s) begin
      rd_r                  <= rd_r + PTR_ONE;
      ufo_out_valid         <= 1'b1;
      ufo_out_data          <= mem_data[rd_r[AW-1:0]];
      ufo_out_startofpacket <= mem_sop[rd_r[AW-1:0]];
      ufo_out_endofpacket   <= mem_eop[rd_r[AW-1:0]];
      ufo_out_empty         <= mem_empty[rd_r[AW-1:0]];
      ufo_out_channel       <= mem_chan[rd_r[AW-1:0]];
    end else if (ufo_out_ready) begin
      ufo_out_valid         <= 1'b0;
    end else begin
      ufo_out_valid         <= ufo_out_valid;
    end
  end

endmodule

// File: tb/tb_ufo_rx_packet_validator.sv
// Randomized bench for ufo_rx_packet_validator; a packet-level reference model
// predicts the forwarded beat stream and the drop count.
module tb_ufo_rx_packet_validator;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic [8:0]  chan;
  } beat_t;

  logic        clk = 1'b0;
  logic        areset_n;
  logic [63:0] rx_data;
  logic        rx_sop, rx_eop, rx_valid, rx_ready;
  logic [2:0]  rx_empty;
  logic [8:0]  rx_chan;
  logic [63:0] out_data;
  logic        out_sop, out_eop, out_valid, out_ready;
  logic [2:0]  out_empty;
  logic [8:0]  out_chan;
  logic        drop_pulse;
  logic [15:0] drop_count;

  int    checks = 0, errors = 0;
  beat_t exp_q[$], got_q[$], cur_q[$], tx_q[$];
  bit    m_open = 1'b0;
  int    m_drops = 0, cmp_idx = 0, pulse_cnt = 0, pulse_base = 0;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  ufo_rx_packet_validator #(.UFO_DATA_WIDTH(64), .MAX_SESSIONS(512), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .areset_n(areset_n),
    .ufo_rx_data(rx_data), .ufo_rx_startofpacket(rx_sop), .ufo_rx_endofpacket(rx_eop),
    .ufo_rx_empty(rx_empty), .ufo_rx_valid(rx_valid), .ufo_rx_channel(rx_chan),
    .ufo_rx_ready(rx_ready),
    .ufo_out_data(out_data), .ufo_out_startofpacket(out_sop), .ufo_out_endofpacket(out_eop),
    .ufo_out_empty(out_empty), .ufo_out_valid(out_valid), .ufo_out_channel(out_chan),
    .ufo_out_ready(out_ready),
    .ufo_drop_pulse(drop_pulse), .ufo_drop_count(drop_count)
  );

  // Output monitor: record transfers and drop pulses mid-cycle.
  always @(negedge clk) begin
    if (areset_n) begin
      if (out_valid && out_ready) got_q.push_back({out_data, out_sop, out_eop, out_empty, out_chan});
      if (drop_pulse) pulse_cnt <= pulse_cnt + 1;
    end
  end

  // Reference model: packet-level interpretation of each accepted beat.
  task automatic model_beat(input beat_t b);
    int bytes;
    int len;
    if (b.sop) begin
      if (m_open) m_drops++;
      cur_q.delete();
      cur_q.push_back(b);
      m_open = 1'b1;
    end else if (m_open) begin
      cur_q.push_back(b);
    end
    if (m_open && cur_q.size() > DEPTH) begin
      m_drops++;
      m_open = 1'b0;
      cur_q.delete();
    end else if (m_open && b.eop) begin
      bytes = cur_q.size() * 8 - int'(b.empty);
      len   = int'(cur_q[0].data[63:48]);
      if (len >= 1 && bytes == len + 2) begin
        foreach (cur_q[i]) begin
          beat_t e;
          e = cur_q[i];
          e.chan = cur_q[0].chan;
          exp_q.push_back(e);
        end
      end else begin
        m_drops++;
      end
      m_open = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input beat_t b, output bit stalled);
    int n = 0;
    rx_valid = 1'b1; rx_data = b.data; rx_sop = b.sop; rx_eop = b.eop;
    rx_empty = b.empty; rx_chan = b.chan;
    stalled = 1'b0;
    while (rx_ready !== 1'b1 && n < 3000) begin tick(); n++; stalled = 1'b1; end
    if (rx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rx_ready_timeout: ready=%b after %0d cycles, required 1", rx_ready, n);
    end else begin
      tick();
      model_beat(b);
    end
    rx_valid = 1'b0;
  endtask

  task automatic build(input int nb, input int emp, input logic [8:0] ch, input logic [15:0] len,
                       input bit with_eop);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.data = {$urandom(), $urandom()};
      if (i == 0) b.data[63:48] = len;
      b.sop   = (i == 0);
      b.eop   = with_eop && (i == nb - 1);
      b.empty = b.eop ? 3'(emp) : 3'd0;
      b.chan  = (i == 0) ? ch : 9'($urandom_range(0, 511));
      tx_q.push_back(b);
    end
  endtask

  task automatic send_tx(input bit gaps, output bit stalled_any);
    beat_t b;
    bit st;
    stalled_any = 1'b0;
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      if (gaps && $urandom_range(0, 3) == 0) tick();
      send_beat(b, st);
      stalled_any |= st;
    end
  endtask

  task automatic check_stream(input string name);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin tick(); n++; end
    repeat (10) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d beats, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = cmp_idx; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat[%0d]: got %h, required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    cmp_idx = exp_q.size();
    checks++;
    if (drop_count !== 16'(m_drops)) begin
      errors++;
      $display("FAIL %s_drop_count: got %0d, required %0d", name, drop_count, m_drops);
    end
    checks++;
    if (pulse_cnt - pulse_base != m_drops) begin
      errors++;
      $display("FAIL %s_drop_pulses: got %0d, required %0d", name, pulse_cnt - pulse_base, m_drops);
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0; rx_valid = 1'b0; rx_data = 64'd0; rx_sop = 1'b0; rx_eop = 1'b0;
    rx_empty = 3'd0; rx_chan = 9'd0; out_ready = 1'b1;
    #1;
    checks++;
    if ({rx_ready, out_valid, out_sop, out_eop, drop_pulse} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {rx_ready, out_valid, out_sop, out_eop, drop_pulse});
    end
    checks++;
    if ({drop_count, out_data, out_empty, out_chan} !== 92'd0) begin
      errors++;
      $display("FAIL reset_values: count=%0d data=%h empty=%0d chan=%0d, required all 0",
               drop_count, out_data, out_empty, out_chan);
    end
    repeat (3) tick();
    areset_n = 1'b1;
    tick();
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, required 1", rx_ready);
    end
  endtask

  task automatic test_single_packet();
    bit st;
    beat_t b;
    build(3, 0, 9'd5, 16'h0016, 1'b1);
    send_tx(1'b0, st);
    b = exp_q[exp_q.size() - 1];
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after eop, required 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, out_sop, out_chan} !== {1'b1, 1'b1, 9'd5}) begin
      errors++;
      $display("FAIL latency_first_beat: valid=%b sop=%b chan=%0d, required 1 1 5 (last %h)",
               out_valid, out_sop, out_chan, b);
    end
    check_stream("single");
  endtask

  task automatic test_bad_empty();
    bit st;
    build(3, 1, 9'd7, 16'h0016, 1'b1);
    build(2, 3, 9'd9, 16'd11, 1'b1);
    send_tx(1'b0, st);
    check_stream("bad_empty");
  endtask

  task automatic test_missing_eop();
    bit st;
    build(2, 0, 9'd12, 16'h0016, 1'b0);
    build(1, 0, 9'd13, 16'd6, 1'b1);
    send_tx(1'b0, st);
    check_stream("missing_eop");
  endtask

  task automatic test_oversize();
    bit st;
    build(70, 0, 9'd20, 16'(70 * 8 - 2), 1'b1);
    build(4, 2, 9'd21, 16'd28, 1'b1);
    send_tx(1'b0, st);
    checks++;
    if (st !== 1'b0) begin
      errors++;
      $display("FAIL oversize_ready: rx_ready dropped during oversize packet, required to stay 1");
    end
    check_stream("oversize");
  endtask

  task automatic test_back_pressure();
    bit st;
    beat_t held;
    out_ready = 1'b0;
    for (int p = 0; p < 14; p++) build(5, 0, 9'(30 + p), 16'd38, 1'b1);
    fork
      send_tx(1'b0, st);
      begin
        int n = 0;
        while (rx_ready === 1'b1 && n < 1500) begin @(posedge clk); #1; n++; end
        checks++;
        if (rx_ready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_ready: rx_ready=%b with output stalled, required 0", rx_ready);
        end
        held = {out_data, out_sop, out_eop, out_empty, out_chan};
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if ({out_valid, rx_ready} !== 2'b10 ||
            {out_data, out_sop, out_eop, out_empty, out_chan} !== held) begin
          errors++;
          $display("FAIL hold_stable: valid=%b ready=%b beat=%h, required 1 0 %h", out_valid,
                   rx_ready, {out_data, out_sop, out_eop, out_empty, out_chan}, held);
        end
        out_ready = 1'b1;
      end
    join
    check_stream("back_pressure");
  endtask

  task automatic test_random();
    bit st;
    beat_t b;
    int t, nb, emp, d;
    rand_ready = 1'b1;
    for (int p = 0; p < 120; p++) begin
      t   = $urandom_range(0, 39);
      nb  = $urandom_range(1, 8);
      emp = (nb == 1) ? $urandom_range(0, 5) : $urandom_range(0, 7);
      if (t < 22) build(nb, emp, 9'($urandom_range(0, 511)), 16'(nb * 8 - emp - 2), 1'b1);
      else if (t < 28) begin
        d = $urandom_range(1, 2);
        if ($urandom_range(0, 1) == 1) d = -d;
        build(nb, emp, 9'($urandom_range(0, 511)), 16'(nb * 8 - emp - 2 + d), 1'b1);
      end
      else if (t < 30) build(1, 6, 9'($urandom_range(0, 511)), 16'd0, 1'b1);
      else if (t < 33) build($urandom_range(1, 4), 0, 9'($urandom_range(0, 511)), 16'd30, 1'b0);
      else if (t < 35) begin
        b.data = {$urandom(), $urandom()}; b.sop = 1'b0; b.eop = 1'($urandom_range(0, 1));
        b.empty = 3'd0; b.chan = 9'($urandom_range(0, 511));
        tx_q.push_back(b);
      end
      else if (t < 37) build(1, 5, 9'($urandom_range(0, 511)), 16'd1, 1'b1);
      else if (t == 37) begin
        nb = $urandom_range(65, 68);
        build(nb, 0, 9'($urandom_range(0, 511)), 16'(nb * 8 - 2), 1'b1);
      end
      else build(64, 4, 9'($urandom_range(0, 511)), 16'(64 * 8 - 6), 1'b1);
      send_tx(1'b1, st);
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check_stream("random");
  endtask

  task automatic test_reset_mid();
    bit st;
    out_ready = 1'b0;
    build(2, 1, 9'd40, 16'd13, 1'b1);
    build(2, 0, 9'd41, 16'd14, 1'b1);
    build(3, 0, 9'd42, 16'd22, 1'b1);
    void'(tx_q.pop_back());
    send_tx(1'b0, st);
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_buffered: out_valid=%b before reset, required 1", out_valid);
    end
    areset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sop, rx_ready, drop_pulse, drop_count} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_cleared: valid=%b sop=%b ready=%b pulse=%b count=%0d, required 0",
               out_valid, out_sop, rx_ready, drop_pulse, drop_count);
    end
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    cur_q.delete();
    m_open = 1'b0; m_drops = 0;
    cmp_idx = exp_q.size();
    repeat (2) tick();
    areset_n = 1'b1;
    pulse_base = pulse_cnt;
    out_ready = 1'b1;
    repeat (30) tick();
    checks++;
    if (got_q.size() != cmp_idx || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_silent: emitted %0d beats count=%0d, required 0 beats count 0",
               got_q.size() - cmp_idx, drop_count);
    end
    build(2, 2, 9'd43, 16'd12, 1'b1);
    send_tx(1'b0, st);
    check_stream("after_reset");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_bad_empty();
    test_missing_eop();
    test_oversize();
    test_back_pressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ufo_rx_packet_validator.md
UFO_RX_PACKET_VALIDATOR -- requirements
Module: ufo_rx_packet_validator

Interface
REQ-001 SHALL have parameter UFO_DATA_WIDTH, default 64, meaning stream width in bits (8 bytes/beat).
REQ-002 SHALL have parameter MAX_SESSIONS, default 512, meaning channel range; channel width is $clog2(MAX_SESSIONS).
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, meaning buffer depth in beats (power of two).
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; areset_n input 1 asynchronous active-low reset.
REQ-005 SHALL have ports ufo_rx_data in UFO_DATA_WIDTH; ufo_rx_startofpacket in 1; ufo_rx_endofpacket in 1; ufo_rx_empty in 3, invalid bytes on eop beat; ufo_rx_valid in 1; ufo_rx_channel in 9, session; ufo_rx_ready out 1.
REQ-006 SHALL have ports ufo_out_data out UFO_DATA_WIDTH; ufo_out_startofpacket out 1; ufo_out_endofpacket out 1; ufo_out_empty out 3; ufo_out_valid out 1; ufo_out_channel out 9; ufo_out_ready in 1.
REQ-007 SHALL have ports ufo_drop_pulse out 1, one-cycle pulse per dropped packet; ufo_drop_count out 16, dropped-packet counter.

Function
REQ-008 SHALL be store-and-forward: no beat of a packet appears on ufo_out until the whole packet is received and validated.
REQ-009 SHALL treat byte 0 as bits [63:56]; bytes 0-1 of the sop beat are the big-endian length field L (bytes following the field), which is kept and not stripped.
REQ-010 SHALL count received bytes as beats*8 - ufo_rx_empty on the eop beat; a packet is good iff count == L+2 and L >= 1.
REQ-011 SHALL transfer on ufo_rx when ufo_rx_valid && ufo_rx_ready, and on ufo_out when ufo_out_valid && ufo_out_ready.
REQ-012 SHALL hold ufo_out_* stable while ufo_out_valid=1 and ufo_out_ready=0.
REQ-013 SHALL keep write pointer wr, commit pointer cm, and read pointer rd (each $clog2(FIFO_DEPTH)+1 bits, wrap-around); entries store data, sop, eop, empty, and the channel captured at sop.
REQ-014 SHALL implement receive FSM states IDLE (wait sop), RECEIVE (writing packet), and DISCARD (consuming oversize packet).
REQ-015 SHALL, in IDLE, write a sop beat and go to RECEIVE, or stay in IDLE if the beat is also eop and complete; a non-sop beat in IDLE is accepted, discarded, and not counted.
REQ-016 SHALL, on an accepted eop of a good packet, set cm <= wr+1 on that edge and return to IDLE.
REQ-017 SHALL, on an accepted eop of a bad packet, set wr <= cm, pulse drop, and return to IDLE.
REQ-018 SHALL, on sop received in RECEIVE (missing eop), drop the open packet (wr <= cm, pulse) and start the new packet from that beat in the same cycle.
REQ-019 SHALL drive ufo_rx_ready = 0 only when the FIFO is full and cm != rd.
REQ-020 SHALL, when the FIFO is full and cm == rd (packet exceeds FIFO_DEPTH), set wr <= cm, pulse drop, enter DISCARD with ufo_rx_ready = 1, and return to IDLE after the eop beat; a sop in DISCARD restarts as in REQ-018 without a second pulse.
REQ-021 SHALL assert ufo_out_valid whenever an entry between rd and cm is presented, with the output registered; the first beat of a packet is valid exactly 2 cycles after its eop beat is accepted if the output is idle.
REQ-022 SHALL allow commit and read in the same cycle and write and read in the same cycle, with no bubble between back-to-back committed packets.
REQ-023 SHALL increment ufo_drop_count once per drop, saturating at 16'hFFFF.

Reset
REQ-024 SHALL, when areset_n=0, immediately clear wr, cm, rd, the FSM (to IDLE), ufo_out_valid, ufo_out_startofpacket, ufo_out_endofpacket, ufo_drop_pulse, and ufo_drop_count; ufo_out_data, ufo_out_empty, and ufo_out_channel reset to 0; ufo_rx_ready is 0 during reset.
REQ-025 SHALL discard any buffered or partial packet on reset mid-operation without counting it, and resume in IDLE.

Verification
REQ-026 SHALL be tested with: 3-beat packet, L=16'h0016, empty=0, channel 5 -> 3 identical beats out on channel 5, first valid 2 cycles after eop, drop_count=0.
REQ-027 SHALL be tested with: 3-beat packet, L=16'h0016, empty=1 -> no output, one drop pulse, drop_count=1, next good packet passes.
REQ-028 SHALL be tested with: sop, beat, then sop of a good 1-beat packet with L=6, empty=0 -> first packet dropped (count 1), second output alone.
REQ-029 SHALL be tested with: FIFO_DEPTH=64, a 70-beat packet then a good packet -> drop at beat 64, ready stays 1, the good packet is output, count=1.
REQ-030 SHALL be tested with: ufo_out_ready=0 while sending good packets until full -> ufo_rx_ready=0; then ready=1 -> all beats out in order with none lost.
REQ-031 SHALL be tested with: areset_n pulsed low mid-packet with 2 committed packets buffered -> outputs cleared, nothing emitted, count=0.
